// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared definitions for the 7-segment scan receiver: active-low
//               segment patterns, special digit codes, receiver FSM states and
//               the anode-to-digit-slot helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Active-low segment patterns, bit 6 = a ... bit 0 = g
    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4F;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4C;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0F;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digit codes that are not plain decimal values
    localparam logic [3:0] CODE_BLANK   = 4'hF;
    localparam logic [3:0] CODE_INVALID = 4'hE;

    // Receiver frame-handling states
    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Maps an active-low anode vector to {valid, slot}; valid only when
    // exactly one anode is driven low.
    function automatic logic [2:0] an_decode(input logic [3:0] an_v);
        logic [2:0] r;
        case (an_v)
            4'b1110: r = 3'b1_00;
            4'b1101: r = 3'b1_01;
            4'b1011: r = 3'b1_10;
            4'b0111: r = 3'b1_11;
            default: r = 3'b0_00;
        endcase
        return r;
    endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_pattern_decode
// Description : Combinational lookup from an active-low 7-segment pattern to a
//               4-bit digit code. Blank maps to CODE_BLANK without error; any
//               unrecognised pattern maps to CODE_INVALID with err set.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       err
);

    // Pattern lookup; anything outside the table is flagged as an error
    always_comb begin
        code = CODE_INVALID;
        err  = 1'b0;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default: begin
                code = CODE_INVALID;
                err  = 1'b1;
            end
        endcase
    end

endmodule : seg_pattern_decode
`default_nettype wire

// File: rtl/seg_scan_receiver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_receiver
// Description : Recovers 4-digit frames from a multiplexed, active-low
//               7-segment display bus. Each digit is sampled once per stable
//               dwell, collected into a working buffer, and presented as a
//               frame with a valid/ready handshake; a frame completed while
//               the previous one is still unaccepted is dropped (overrun).
//               Optional macro SEG_RX_DP_EN adds decimal-point capture
//               (input dp, output frame_dp).
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_receiver
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
`ifdef SEG_RX_DP_EN
    input  logic        dp,
    output logic [3:0]  frame_dp,
`endif
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [15:0] frame_digits,
    output logic [3:0]  frame_err,
    output logic        overrun
);

    localparam logic [7:0] C_STABLE    = 8'(STABLE_CYCLES);
    localparam logic [7:0] C_STABLE_M1 = 8'(STABLE_CYCLES - 1);

    // Input stage and previous-cycle copy used for stability detection
    logic [3:0]  r_an, r_prev_an;
    logic [6:0]  r_seg, r_prev_seg;
    logic [7:0]  r_cnt;
    logic [15:0] r_buf_digits;
    logic [3:0]  r_buf_err;
    logic [3:0]  r_mask;
    state_t      r_state;
    logic        r_frame_valid;
    logic [15:0] r_frame_digits;
    logic [3:0]  r_frame_err;
    logic        r_overrun;

    logic [2:0]  w_an_dec;
    logic        w_an_ok;
    logic [1:0]  w_slot;
    logic        w_same;
    logic        w_sample;
    logic [7:0]  w_cnt_nxt;
    logic [3:0]  w_code;
    logic        w_code_err;
    logic [15:0] w_buf_digits_nxt;
    logic [3:0]  w_buf_err_nxt;
    logic [3:0]  w_mask_nxt;
    logic        w_complete;

`ifdef SEG_RX_DP_EN
    logic        r_dp;
    logic [3:0]  r_buf_dp;
    logic [3:0]  r_frame_dp;
    logic [3:0]  w_buf_dp_nxt;
`endif

    assign w_an_dec = an_decode(r_an);
    assign w_an_ok  = w_an_dec[2];
    assign w_slot   = w_an_dec[1:0];
    assign w_same   = (r_an == r_prev_an) && (r_seg == r_prev_seg);

    // The counter is one below threshold and this cycle still matches: the
    // dwell has just become long enough, so take exactly one sample.
    assign w_sample = w_an_ok && w_same && (r_cnt == C_STABLE_M1);

    seg_pattern_decode u_decode (
        .seg  (r_seg),
        .code (w_code),
        .err  (w_code_err)
    );

    // Stability counter: cleared on bad anodes, reloaded on change, saturating
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!w_an_ok) begin
            w_cnt_nxt = 8'd0;
        end else if (!w_same) begin
            w_cnt_nxt = 8'd1;
        end else if (r_cnt < C_STABLE) begin
            w_cnt_nxt = r_cnt + 8'd1;
        end
    end

    // Working buffer and capture mask including the sample taken this cycle
    always_comb begin
        w_buf_digits_nxt = r_buf_digits;
        w_buf_err_nxt    = r_buf_err;
        w_mask_nxt       = r_mask;
`ifdef SEG_RX_DP_EN
        w_buf_dp_nxt     = r_buf_dp;
`endif
        if (w_sample) begin
            w_buf_digits_nxt[{w_slot, 2'b00} +: 4] = w_code;
            w_buf_err_nxt[w_slot]                  = w_code_err;
            w_mask_nxt[w_slot]                     = 1'b1;
`ifdef SEG_RX_DP_EN
            w_buf_dp_nxt[w_slot]                   = ~r_dp;
`endif
        end
    end

    assign w_complete = w_sample && (w_mask_nxt == 4'hF);

    // Front end: input register, dwell tracking and working buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an         <= 4'h0;
            r_seg        <= 7'h00;
            r_prev_an    <= 4'h0;
            r_prev_seg   <= 7'h00;
            r_cnt        <= 8'd0;
            r_buf_digits <= 16'h0000;
            r_buf_err    <= 4'h0;
`ifdef SEG_RX_DP_EN
            r_dp         <= 1'b1;
            r_buf_dp     <= 4'h0;
`endif
        end else begin
            r_an         <= an;
            r_seg        <= seg;
            r_prev_an    <= r_an;
            r_prev_seg   <= r_seg;
            r_cnt        <= w_cnt_nxt;
            r_buf_digits <= w_buf_digits_nxt;
            r_buf_err    <= w_buf_err_nxt;
`ifdef SEG_RX_DP_EN
            r_dp         <= dp;
            r_buf_dp     <= w_buf_dp_nxt;
`endif
        end
    end

    // Frame FSM: capture mask, frame presentation and overrun reporting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= COLLECT;
            r_mask         <= 4'h0;
            r_frame_valid  <= 1'b0;
            r_frame_digits <= 16'h0000;
            r_frame_err    <= 4'h0;
            r_overrun      <= 1'b0;
`ifdef SEG_RX_DP_EN
            r_frame_dp     <= 4'h0;
`endif
        end else begin
            r_overrun <= 1'b0;
            case (r_state)
                COLLECT: begin
                    if (w_complete) begin
                        r_frame_digits <= w_buf_digits_nxt;
                        r_frame_err    <= w_buf_err_nxt;
`ifdef SEG_RX_DP_EN
                        r_frame_dp     <= w_buf_dp_nxt;
`endif
                        r_frame_valid  <= 1'b1;
                        r_mask         <= 4'h0;
                        r_state        <= PRESENT;
                    end else begin
                        r_mask <= w_mask_nxt;
                    end
                end
                PRESENT: begin
                    if (w_complete) begin
                        r_mask <= 4'h0;
                        if (frame_ready) begin
                            // Old frame is taken this cycle; new one follows directly
                            r_frame_digits <= w_buf_digits_nxt;
                            r_frame_err    <= w_buf_err_nxt;
`ifdef SEG_RX_DP_EN
                            r_frame_dp     <= w_buf_dp_nxt;
`endif
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end else begin
                        r_mask <= w_mask_nxt;
                        if (frame_ready) begin
                            r_frame_valid <= 1'b0;
                            r_state       <= COLLECT;
                        end
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign frame_valid  = r_frame_valid;
    assign frame_digits = r_frame_digits;
    assign frame_err    = r_frame_err;
    assign overrun      = r_overrun;
`ifdef SEG_RX_DP_EN
    assign frame_dp     = r_frame_dp;
`endif

endmodule : seg_scan_receiver
`default_nettype wire

// File: tb/tb_seg_scan_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_receiver
// Description : Directed bench for seg_scan_receiver. Expected frames are
//               queued when a scan is driven and compared when the receiver
//               presents a frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_receiver;
    import seg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_drv;
    logic        frame_valid;
    logic        frame_ready;
    logic [15:0] frame_digits;
    logic [3:0]  frame_err;
    logic        overrun;
`ifdef SEG_RX_DP_EN
    logic [3:0]  frame_dp;
`endif

    int checks = 0;
    int errors = 0;
    int n_frames = 0;
    int valid_cycles = 0;
    int ov_cycles = 0;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  e;
        logic [3:0]  p;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    seg_scan_receiver #(.STABLE_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .an           (an),
        .seg          (seg),
`ifdef SEG_RX_DP_EN
        .dp           (dp_drv),
        .frame_dp     (frame_dp),
`endif
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_digits (frame_digits),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p);
        exp_t x;
        x.d = d;
        x.e = e;
        x.p = p;
        exp_q.push_back(x);
    endtask

    // Entered at posedge+1; leaves at posedge+1 after n held cycles
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        an     = a;
        seg    = s;
        dp_drv = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        hold(4'hF, SEG_BLANK, 1'b1, n);
    endtask

    // dpn: active-low decimal point per digit
    task automatic scan_frame(input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0,
                              input logic [3:0] dpn);
        hold(4'b0111, s3, dpn[3], 6);
        hold(4'b1011, s2, dpn[2], 6);
        hold(4'b1101, s1, dpn[1], 6);
        hold(4'b1110, s0, dpn[0], 6);
        idle(6);
    endtask

    // Scoreboard side: detect each newly presented frame and compare it
    initial begin
        logic prev_valid = 1'b0;
        logic prev_ready = 1'b0;
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (frame_valid) valid_cycles++;
                if (overrun) ov_cycles++;
                if (frame_valid && (!prev_valid || prev_ready)) begin
                    n_frames++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        x = exp_q.pop_front();
                        chk("frame_digits", frame_digits, x.d);
                        chk("frame_err", frame_err, x.e);
`ifdef SEG_RX_DP_EN
                        chk("frame_dp", frame_dp, x.p);
`endif
                    end
                end
                prev_valid = frame_valid;
                prev_ready = frame_ready;
            end
        end
    end

    initial begin
        int f0, v0, o0;
        rst = 1'b1;
        an = 4'hF;
        seg = SEG_BLANK;
        dp_drv = 1'b1;
        frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", frame_valid, 0);
        chk("rst_digits", frame_digits, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
`ifdef SEG_RX_DP_EN
        chk("rst_dp", frame_dp, 0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(4);
        chk("idle_valid", frame_valid, 0);

        // Basic frame 4321, dp on digit 1, single-cycle valid with ready high
        f0 = n_frames;
        v0 = valid_cycles;
        expect_frame(16'h4321, 4'h0, 4'b0010);
        scan_frame(SEG_4, SEG_3, SEG_2, SEG_1, 4'b1101);
        chk("f4321_count", n_frames - f0, 1);
        chk("f4321_valid_len", valid_cycles - v0, 1);

        // Unrecognised pattern on digit 2
        f0 = n_frames;
        expect_frame(16'h4E21, 4'b0100, 4'h0);
        scan_frame(SEG_4, 7'h55, SEG_2, SEG_1, 4'hF);
        chk("f4E21_count", n_frames - f0, 1);

        // Short dwell on digit 0 must not sample; the later full dwell completes
        f0 = n_frames;
        hold(4'b0111, SEG_4, 1'b1, 6);
        hold(4'b1011, SEG_3, 1'b1, 6);
        hold(4'b1101, SEG_2, 1'b1, 6);
        hold(4'b1110, SEG_9, 1'b1, 3);
        idle(8);
        chk("short_dwell_frames", n_frames - f0, 0);
        chk("short_dwell_valid", frame_valid, 0);
        expect_frame(16'h4328, 4'h0, 4'h0);
        hold(4'b1110, SEG_8, 1'b1, 6);
        idle(6);
        chk("short_dwell_done", n_frames - f0, 1);

        // Two frames with ready low: first held, second dropped with overrun
        frame_ready = 1'b0;
        f0 = n_frames;
        o0 = ov_cycles;
        expect_frame(16'h1234, 4'h0, 4'h0);
        scan_frame(SEG_1, SEG_2, SEG_3, SEG_4, 4'hF);
        scan_frame(SEG_5, SEG_6, SEG_7, SEG_8, 4'hF);
        chk("ovr_valid_held", frame_valid, 1);
        chk("ovr_digits_held", frame_digits, 16'h1234);
        chk("ovr_pulses", ov_cycles - o0, 1);
        chk("ovr_frames", n_frames - f0, 1);
        frame_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ovr_valid_drop", frame_valid, 0);
        @(posedge clk);
        #1;

        // Multiple anodes low: nothing captured
        f0 = n_frames;
        hold(4'b0011, SEG_1, 1'b1, 10);
        idle(6);
        chk("multi_an_frames", n_frames - f0, 0);
        chk("multi_an_valid", frame_valid, 0);

        // Reset after three digits: partial capture discarded
        hold(4'b0111, SEG_9, 1'b1, 6);
        hold(4'b1011, SEG_9, 1'b1, 6);
        hold(4'b1101, SEG_9, 1'b1, 6);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", frame_valid, 0);
        chk("mid_rst_digits", frame_digits, 0);
        chk("mid_rst_err", frame_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        f0 = n_frames;
        hold(4'b1110, SEG_5, 1'b1, 6);
        idle(8);
        chk("post_rst_no_frame", n_frames - f0, 0);
        expect_frame(16'hF765, 4'h0, 4'h0);
        hold(4'b0111, SEG_BLANK, 1'b1, 6);
        hold(4'b1011, SEG_7, 1'b1, 6);
        hold(4'b1101, SEG_6, 1'b1, 6);
        idle(6);
        chk("post_rst_frame", n_frames - f0, 1);

        chk("queue_empty", exp_q.size(), 0);
        chk("total_frames", n_frames, 5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seg_scan_receiver
`default_nettype wire

// File: doc/seg_scan_receiver.md
SEG_SCAN_RECEIVER -- requirements
Module: seg_scan_receiver

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical cycles of (an, seg) required before a digit is sampled; legal range 2..255.
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port an  input  4  digit anodes, active-low; an[0] = digit 0 (rightmost).
REQ-005 SHALL have port seg  input  7  segment cathodes, active-low; seg[6]=a ... seg[0]=g.
REQ-006 SHALL have port frame_valid  output  1  completed 4-digit frame available.
REQ-007 SHALL have port frame_ready  input  1  consumer accepts frame.
REQ-008 SHALL have port frame_digits  output  16  digit n at [4n+3:4n].
REQ-009 SHALL have port frame_err  output  4  bit n set = digit n held an unrecognised pattern.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse, completed frame dropped.

Function
REQ-011 SHALL register an and seg once before all other use.
REQ-012 SHALL treat an as valid only when exactly one bit is 0; invalid an clears the stability counter.
REQ-013 SHALL count cycles with valid an and (an, seg) equal to the previous cycle; any change reloads the counter to 1.
REQ-014 SHALL sample the digit once per dwell, on the cycle the counter reaches STABLE_CYCLES; no resample until (an, seg) changes; counter saturates.
REQ-015 SHALL decode seg: 7'h01->0, 7'h4F->1, 7'h12->2, 7'h06->3, 7'h4C->4, 7'h24->5, 7'h20->6, 7'h0F->7, 7'h00->8, 7'h04->9, 7'h7F (blank)->4'hF with err=0; any other pattern->4'hE with err=1.
REQ-016 SHALL write each sample into a working buffer slot selected by an, overwriting any earlier sample of that digit, and set that slot's bit in a 4-bit captured mask.
REQ-017 SHALL implement FSM states COLLECT and PRESENT; frame completion = mask becomes 4'hF (including the completing sample).
REQ-018 In COLLECT on completion SHALL copy buffer to frame_digits/frame_err, assert frame_valid next cycle, clear mask, go PRESENT.
REQ-019 In PRESENT SHALL hold frame outputs stable and keep collecting; frame_valid && frame_ready with no completion -> frame_valid low next cycle, go COLLECT.
REQ-020 In PRESENT, completion with frame_ready high same cycle SHALL load the new frame, keep frame_valid high, stay PRESENT.
REQ-021 In PRESENT, completion with frame_ready low SHALL discard the new frame, clear mask, pulse overrun for one cycle, keep old frame.
REQ-022 Latency: stable dwell start to sample = STABLE_CYCLES+1 cycles (input register included); completing sample to frame_valid = 1 cycle.

Reset
REQ-023 rst SHALL asynchronously force: state COLLECT, mask 0, counter 0, buffer 0, frame_valid 0, frame_digits 16'h0000, frame_err 4'h0, overrun 0.
REQ-024 Reset mid-frame SHALL discard partial captures; collection restarts from an empty mask after release.

Configuration
REQ-025 Macro SEG_RX_DP_EN SHALL, when defined, add input dp (1, active-low decimal point) sampled with seg, and output frame_dp (4, bit n = digit n dp lit, active-high), reset 0, following the same buffer/present rules.
REQ-026 Without SEG_RX_DP_EN, dp and frame_dp SHALL not exist and behaviour is otherwise identical.

Structure
REQ-027 Segment constants (SEG_0..SEG_9, SEG_BLANK), codes CODE_BLANK=4'hF, CODE_INVALID=4'hE and the state enumeration SHALL live in shared package seg_pkg.
REQ-028 Pattern-to-code lookup SHALL be sub-module seg_pattern_decode (combinational, seg in, code + err out).

Verification
REQ-029 Scan digits 3,2,1,0 = 7'h4C,7'h06,7'h12,7'h4F, 6 cycles each, ready=1 -> frame_valid one cycle, frame_digits=16'h4321, frame_err=0.
REQ-030 Same scan with digit 2 = 7'h55 -> frame_digits=16'h4E21, frame_err=4'b0100.
REQ-031 Dwell of STABLE_CYCLES-1 cycles on digit 0 then switch -> no sample, no frame.
REQ-032 Two full frames, ready=0 -> first frame held, overrun pulses once; ready=1 then -> frame_valid drops next cycle.
REQ-033 an=4'b0011 for 10 cycles -> no capture; rst asserted after 3 digits captured -> all outputs 0, next frame requires 4 fresh digits.
REQ-034 With SEG_RX_DP_EN, dp=0 on digit 1 only -> frame_dp=4'b0010; blank 7'h7F on digit 3 -> nibble 4'hF, err 0.
